// File: rtl/ei_mac_ctrl_pkg.sv
// Shared state type and constants for the ei_mac_dot_ctrl dot-product sequencer.
package ei_mac_ctrl_pkg;

    localparam int unsigned ACC_W       = 32;
    localparam int unsigned OP_W        = 8;
    localparam int unsigned WDOG_MARGIN = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        HOLD   = 3'd4
    } state_e;

endpackage

// File: rtl/ei_mac_dot_ctrl.sv
// Sequences one ei_mac8x8_pipe through a dot product of length len and holds the result.
// Optional DRAIN watchdog enabled by defining EI_MAC_CTRL_WDOG_EN.
module ei_mac_dot_ctrl
    import ei_mac_ctrl_pkg::*;
#(
    parameter int unsigned LAT   = 3,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [OP_W-1:0]  op_a,
    input  logic [OP_W-1:0]  op_b,
    output logic             mac_en,
    output logic             mac_clr,
    output logic             mac_valid,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    input  logic [ACC_W-1:0] mac_acc,
    input  logic             mac_vout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_err,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0] ret_cnt_q, ret_cnt_d;
    logic             mac_clr_q, mac_clr_d;
    logic             mac_valid_q, mac_valid_d;
    logic [OP_W-1:0]  mac_a_q, mac_a_d;
    logic [OP_W-1:0]  mac_b_q, mac_b_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;

    logic op_fire;
    logic ret_inc;
    logic ret_done;
    logic issue_last;

`ifdef EI_MAC_CTRL_WDOG_EN
    localparam logic [7:0] WDOG_LIMIT = 8'(LAT + WDOG_MARGIN);

    logic [7:0] wdog_q, wdog_d;
    logic       res_err_q, res_err_d;
    logic       wdog_expired;

    assign wdog_expired = (wdog_q + 8'd1) == WDOG_LIMIT;
    assign res_err      = res_err_q;
`else
    localparam logic [7:0] WDOG_LIMIT = 8'(LAT + WDOG_MARGIN);

    logic unused_wdog_limit;

    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign res_err           = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign mac_en    = busy;
    assign res_valid = (state_q == HOLD);
    assign op_ready  = (state_q == STREAM) && (issue_cnt_q < len_q);
    assign mac_clr   = mac_clr_q;
    assign mac_valid = mac_valid_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_data  = res_data_q;

    assign op_fire    = op_valid && op_ready;
    assign ret_inc    = mac_vout && ((state_q == STREAM) || (state_q == DRAIN));
    assign issue_last = (issue_cnt_q + LEN_W'(1)) == len_q;
    // Includes a return landing this cycle so the final mac_acc is captured alongside its valid.
    assign ret_done   = (ret_cnt_q + LEN_W'(ret_inc)) == len_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_inc ? (ret_cnt_q + LEN_W'(1)) : ret_cnt_q;
        mac_clr_d   = 1'b0;
        mac_valid_d = 1'b0;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        res_data_d  = res_data_q;
`ifdef EI_MAC_CTRL_WDOG_EN
        wdog_d      = wdog_q;
        res_err_d   = res_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef EI_MAC_CTRL_WDOG_EN
                    res_err_d = 1'b0;
`endif
                    if (len != '0) begin
                        len_d     = len;
                        mac_clr_d = 1'b1;
                        state_d   = CLR;
                    end else begin
                        res_data_d = '0;
                        state_d    = HOLD;
                    end
                end
            end

            CLR: begin
                issue_cnt_d = '0;
                ret_cnt_d   = '0;
                state_d     = STREAM;
            end

            STREAM: begin
                if (op_fire) begin
                    mac_valid_d = 1'b1;
                    mac_a_d     = op_a;
                    mac_b_d     = op_b;
                    issue_cnt_d = issue_cnt_q + LEN_W'(1);
                    if (issue_last) begin
                        state_d = DRAIN;
`ifdef EI_MAC_CTRL_WDOG_EN
                        wdog_d  = '0;
`endif
                    end
                end
            end

            DRAIN: begin
                if (ret_done) begin
                    res_data_d = mac_acc;
                    state_d    = HOLD;
                end
`ifdef EI_MAC_CTRL_WDOG_EN
                else begin
                    wdog_d = wdog_q + 8'd1;
                    if (wdog_expired) begin
                        res_data_d = mac_acc;
                        res_err_d  = 1'b1;
                        state_d    = HOLD;
                    end
                end
`endif
            end

            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            mac_clr_q   <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_data_q  <= '0;
`ifdef EI_MAC_CTRL_WDOG_EN
            wdog_q      <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            mac_clr_q   <= mac_clr_d;
            mac_valid_q <= mac_valid_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            res_data_q  <= res_data_d;
`ifdef EI_MAC_CTRL_WDOG_EN
            wdog_q      <= wdog_d;
            res_err_q   <= res_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ei_mac_dot_ctrl.sv
// Directed self-checking bench for ei_mac_dot_ctrl driving a behavioural pipelined MAC.
module tb_ei_mac_dot_ctrl;

    localparam int unsigned LAT   = 3;
    localparam int unsigned LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [7:0]       op_a = '0;
    logic [7:0]       op_b = '0;
    logic             mac_en, mac_clr, mac_valid;
    logic [7:0]       mac_a, mac_b;
    logic [31:0]      mac_acc;
    logic             mac_vout;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_data;
    logic             res_err;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc_cyc = 0;

    // Expectations set by the driver for the job in flight.
    int          exp_len = 0;
    logic [31:0] exp_res = '0;
    logic        exp_err = 1'b0;
    logic        drop_en = 1'b0;

    // Per-job observations owned by the compare process.
    int          job_acc = 0;
    int          job_clr = 0;
    int          job_val = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ei_mac_dot_ctrl #(.LAT(LAT), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_valid(mac_valid),
        .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc), .mac_vout(mac_vout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy)
    );

    // Behavioural MAC: LAT-deep product pipe, registered acc/valid_out; optionally loses its first return.
    logic [LAT-1:0] pv;
    logic [15:0]    pp [LAT];
    logic [31:0]    acc_q;
    logic           vout_q;
    int             ret_seen;

    assign mac_acc  = acc_q;
    assign mac_vout = vout_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv       <= '0;
            acc_q    <= '0;
            vout_q   <= 1'b0;
            ret_seen <= 0;
        end else if (mac_en) begin
            pv    <= {pv[LAT-2:0], mac_valid};
            pp[0] <= 16'(mac_a) * 16'(mac_b);
            for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
            vout_q <= 1'b0;
            if (mac_clr) begin
                acc_q    <= '0;
                ret_seen <= 0;
            end else if (pv[LAT-1]) begin
                ret_seen <= ret_seen + 1;
                if (!(drop_en && ret_seen == 0)) begin
                    acc_q  <= acc_q + 32'(pp[LAT-1]);
                    vout_q <= 1'b1;
                end
            end
        end else begin
            vout_q <= 1'b0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Compare process: protocol and data rules checked every cycle outputs are meaningful.
    always @(negedge clk) begin
        logic [15:0] pr;
        if (rst) begin
            sb.delete();
            job_acc = 0;
            job_clr = 0;
            job_val = 0;
        end else begin
            check("mac_en_eq_busy", {31'd0, mac_en}, {31'd0, busy});
            if (!busy) begin
                check("op_ready_idle", {31'd0, op_ready}, 32'd0);
                check("res_valid_idle", {31'd0, res_valid}, 32'd0);
                if (start) begin
                    sb.delete();
                    job_acc = 0;
                    job_clr = 0;
                    job_val = 0;
                end
            end
`ifndef EI_MAC_CTRL_WDOG_EN
            check("res_err_tied0", {31'd0, res_err}, 32'd0);
`endif
            if (mac_clr) job_clr++;
            if (mac_valid) begin
                job_val++;
                check("clr_before_valid", 32'(job_clr), 32'd1);
                if (sb.size() == 0) begin
                    check("mac_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    pr = sb.pop_front();
                    check("mac_operands", {16'd0, mac_a, mac_b}, {16'd0, pr});
                end
            end
            if (job_acc >= exp_len) check("op_ready_full", {31'd0, op_ready}, 32'd0);
            if (op_valid && op_ready) begin
                job_acc++;
                sb.push_back({op_a, op_b});
            end
            if (res_valid) begin
                check("res_data_model", res_data, exp_res);
                check("res_err_model", {31'd0, res_err}, {31'd0, exp_err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input logic [63:0] av, input logic [63:0] bv, input int gap);
        int w;
        for (int i = 0; i < n; i++) begin
            op_valid = 1'b1;
            op_a     = av[i*8 +: 8];
            op_b     = bv[i*8 +: 8];
            w = 0;
            while (!op_ready && w < 50) begin
                tick();
                w++;
            end
            if (!op_ready) begin
                check("feed_timeout", {31'd0, op_ready}, 32'd1);
                op_valid = 1'b0;
                return;
            end
            tick();
            last_acc_cyc = cyc;
            if (gap > 0) begin
                op_valid = 1'b0;
                if (i == 0) begin
                    start = 1'b1;
                    len   = 8'd5;
                end
                repeat (gap) begin
                    tick();
                    start = 1'b0;
                end
            end
        end
        op_valid = 1'b0;
    endtask

    task automatic run_job(input int n, input logic [63:0] av, input logic [63:0] bv,
                           input int gap, input int rdelay, input logic [31:0] lit,
                           input logic drop, input string nm);
        int w;
        logic [31:0] sum = '0;
        for (int i = 0; i < n; i++)
            if (!(drop && i == 0)) sum += 32'(av[i*8 +: 8]) * 32'(bv[i*8 +: 8]);
        exp_len = n;
        exp_res = sum;
        exp_err = drop;
        drop_en = drop;
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        if (n == 0) check({nm, "_len0_one_cycle"}, {31'd0, res_valid}, 32'd1);
        feed(n, av, bv, gap);
        if (n > 0) check({nm, "_op_ready_after_last"}, {31'd0, op_ready}, 32'd0);
        w = 0;
        while (!res_valid && w < 200) begin
            tick();
            w++;
        end
        check({nm, "_res_valid_arrives"}, {31'd0, res_valid}, 32'd1);
        if (drop) check({nm, "_wdog_latency"}, 32'(cyc - last_acc_cyc), 32'(LAT + 8));
        check({nm, "_res_data"}, res_data, lit);
        check({nm, "_res_err"}, {31'd0, res_err}, {31'd0, drop});
        repeat (rdelay) tick();
        check({nm, "_res_data_held"}, res_data, lit);
        res_ready = 1'b1;
        start = 1'b1;
        len   = 8'd3;
        tick();
        res_ready = 1'b0;
        start = 1'b0;
        check({nm, "_busy_fall"}, {31'd0, busy}, 32'd0);
        check({nm, "_res_valid_drop"}, {31'd0, res_valid}, 32'd0);
        check({nm, "_mac_valid_count"}, 32'(job_val), 32'(n));
        check({nm, "_mac_clr_count"}, 32'(job_clr), (n != 0) ? 32'd1 : 32'd0);
        drop_en = 1'b0;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_op_ready", {31'd0, op_ready}, 32'd0);
        check("rst_mac_en", {31'd0, mac_en}, 32'd0);
        check("rst_mac_clr", {31'd0, mac_clr}, 32'd0);
        check("rst_mac_valid", {31'd0, mac_valid}, 32'd0);
        check("rst_mac_ab", {16'd0, mac_a, mac_b}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_err", {31'd0, res_err}, 32'd0);
        rst = 1'b0;
        tick();

        run_job(3, 64'h050A03, 64'h050204, 0, 0, 32'd57, 1'b0, "b2b3");
        run_job(3, 64'h050A03, 64'h050204, 2, 5, 32'd57, 1'b0, "gaps3");
        run_job(0, 64'h0, 64'h0, 0, 2, 32'd0, 1'b0, "len0");
        run_job(1, 64'h03, 64'h04, 0, 0, 32'd12, 1'b0, "job_a");
        run_job(2, 64'hFFFF, 64'hFFFF, 0, 0, 32'd130050, 1'b0, "job_b");

        exp_len = 4;
        exp_res = '0;
        exp_err = 1'b0;
        start = 1'b1;
        len   = 8'd4;
        tick();
        start = 1'b0;
        feed(2, 64'h0201, 64'h0201, 0);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_op_ready", {31'd0, op_ready}, 32'd0);
        check("midrst_mac_valid", {31'd0, mac_valid}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_job(1, 64'h07, 64'h06, 0, 0, 32'd42, 1'b0, "after_rst");

`ifdef EI_MAC_CTRL_WDOG_EN
        run_job(2, 64'h0402, 64'h0503, 0, 2, 32'd20, 1'b1, "wdog");
        run_job(1, 64'h02, 64'h02, 0, 0, 32'd4, 1'b0, "post_wdog");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
